// File: rtl/lca_pkg.sv
// Shared constants and types for the write-back stage of the LCA pipeline.
package lca_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned LM_STRIDE = 1;

    localparam logic [2:0] REG_PC = 3'd7;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_LM   = 1'b1
    } wb_state_t;

endpackage

// File: rtl/reg_writeback_prio_enc8.sv
// 8-bit lowest-set-bit encoder used to pick the next load-multiple destination.
module prio_enc8 (
    input  logic [7:0] vec,
    output logic [2:0] idx,
    output logic       any
);

    always_comb begin
        idx = 3'd0;
        // Scan high to low so the lowest set bit is the last one assigned.
        for (int unsigned i = 8; i > 0; i--) begin
            if (vec[i-1]) begin
                idx = 3'(i - 1);
            end
        end
        any = |vec;
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage: retires one instruction per cycle into R0-R6 and R7 (PC),
// and sequences load-multiple bursts one memory word per cycle.
module reg_writeback #(
    parameter int unsigned DATA_W    = lca_pkg::DATA_W,
    parameter int unsigned ADDR_W    = lca_pkg::ADDR_W,
    parameter int unsigned LM_STRIDE = lca_pkg::LM_STRIDE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inValid,
    output logic              inReady,
    input  logic              inRegWrite,
    input  logic [ADDR_W-1:0] inAdd,
    input  logic [DATA_W-1:0] inData,
    input  logic [DATA_W-1:0] inPcNext,
    input  logic              inIsLM,
    input  logic [7:0]        inLMList,
    input  logic [DATA_W-1:0] inLMBase,
    output logic [DATA_W-1:0] memAddr,
    input  logic [DATA_W-1:0] memData,
    output logic              rfWrite,
    output logic [ADDR_W-1:0] rfWriteAdd,
    output logic [DATA_W-1:0] rfIn,
    output logic              rfWriteR7,
    output logic [DATA_W-1:0] rfInR7,
    output logic              retired
);

    import lca_pkg::*;

    localparam logic [DATA_W-1:0] STRIDE  = DATA_W'(LM_STRIDE);
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(REG_PC);

    wb_state_t         state_q, state_d;
    logic [7:0]        list_q, list_d;
    logic [DATA_W-1:0] offset_q, offset_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] pc_next_q, pc_next_d;

    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rf_write_add_q, rf_write_add_d;
    logic [DATA_W-1:0] rf_in_q, rf_in_d;
    logic              rf_write_r7_q, rf_write_r7_d;
    logic [DATA_W-1:0] rf_in_r7_q, rf_in_r7_d;
    logic              retired_q, retired_d;

    logic [2:0]        lm_idx;
    logic              lm_any;
    logic              lm_last;
    logic              accept;

    prio_enc8 u_prio_enc8 (
        .vec (list_q),
        .idx (lm_idx),
        .any (lm_any)
    );

    assign inReady = (state_q == WB_IDLE);
    assign accept  = inValid && inReady;
    // Remaining list is one-hot when clearing its lowest bit leaves nothing.
    assign lm_last = ((list_q & (list_q - 8'd1)) == 8'h00);

    always_comb begin
        memAddr = '0;
        if (state_q == WB_LM) begin
            memAddr = base_q + offset_q * STRIDE;
        end
    end

    always_comb begin
        state_d        = state_q;
        list_d         = list_q;
        offset_d       = offset_q;
        base_d         = base_q;
        pc_next_d      = pc_next_q;
        rf_write_d     = 1'b1;
        rf_write_add_d = rf_write_add_q;
        rf_in_d        = rf_in_q;
        rf_write_r7_d  = 1'b1;
        rf_in_r7_d     = rf_in_r7_q;
        retired_d      = 1'b0;

        unique case (state_q)
            WB_IDLE: begin
                if (accept) begin
                    if (inIsLM && (inLMList != 8'h00)) begin
                        list_d    = inLMList;
                        base_d    = inLMBase;
                        pc_next_d = inPcNext;
                        offset_d  = '0;
                        state_d   = WB_LM;
                    end else begin
                        rf_write_r7_d = 1'b0;
                        rf_in_r7_d    = inPcNext;
                        retired_d     = 1'b1;
                        if (!inIsLM && inRegWrite) begin
                            // A result destined for R7 overrides the PC commit.
                            if (inAdd == PC_ADDR) begin
                                rf_in_r7_d = inData;
                            end else begin
                                rf_write_d     = 1'b0;
                                rf_write_add_d = inAdd;
                                rf_in_d        = inData;
                            end
                        end
                    end
                end
            end
            WB_LM: begin
                if (lm_any) begin
                    if (lm_idx == REG_PC) begin
                        rf_write_r7_d = 1'b0;
                        rf_in_r7_d    = memData;
                    end else begin
                        rf_write_d     = 1'b0;
                        rf_write_add_d = ADDR_W'(lm_idx);
                        rf_in_d        = memData;
                    end
                    list_d   = list_q & (list_q - 8'd1);
                    offset_d = offset_q + DATA_W'(1);
                end
                if (lm_last) begin
                    retired_d = 1'b1;
                    state_d   = WB_IDLE;
                    if (lm_idx != REG_PC) begin
                        rf_write_r7_d = 1'b0;
                        rf_in_r7_d    = pc_next_q;
                    end
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= WB_IDLE;
            list_q         <= '0;
            offset_q       <= '0;
            base_q         <= '0;
            pc_next_q      <= '0;
            rf_write_q     <= 1'b1;
            rf_write_add_q <= '0;
            rf_in_q        <= '0;
            rf_write_r7_q  <= 1'b1;
            rf_in_r7_q     <= '0;
            retired_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            list_q         <= list_d;
            offset_q       <= offset_d;
            base_q         <= base_d;
            pc_next_q      <= pc_next_d;
            rf_write_q     <= rf_write_d;
            rf_write_add_q <= rf_write_add_d;
            rf_in_q        <= rf_in_d;
            rf_write_r7_q  <= rf_write_r7_d;
            rf_in_r7_q     <= rf_in_r7_d;
            retired_q      <= retired_d;
        end
    end

    assign rfWrite    = rf_write_q;
    assign rfWriteAdd = rf_write_add_q;
    assign rfIn       = rf_in_q;
    assign rfWriteR7  = rf_write_r7_q;
    assign rfInR7     = rf_in_r7_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed cases plus randomized traffic
// against a queue-of-pending-writes reference model.
module tb_reg_writeback;

    localparam int unsigned STRIDE = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic        inRegWrite;
    logic [2:0]  inAdd;
    logic [15:0] inData;
    logic [15:0] inPcNext;
    logic        inIsLM;
    logic [7:0]  inLMList;
    logic [15:0] inLMBase;
    logic [15:0] memAddr;
    logic [15:0] memData;
    logic        rfWrite;
    logic [2:0]  rfWriteAdd;
    logic [15:0] rfIn;
    logic        rfWriteR7;
    logic [15:0] rfInR7;
    logic        retired;

    logic [15:0] mem_key;

    // Asynchronous memory: word at address a is a + mem_key.
    assign memData = memAddr + mem_key;

    reg_writeback #(
        .DATA_W    (16),
        .ADDR_W    (3),
        .LM_STRIDE (STRIDE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .inValid    (inValid),
        .inReady    (inReady),
        .inRegWrite (inRegWrite),
        .inAdd      (inAdd),
        .inData     (inData),
        .inPcNext   (inPcNext),
        .inIsLM     (inIsLM),
        .inLMList   (inLMList),
        .inLMBase   (inLMBase),
        .memAddr    (memAddr),
        .memData    (memData),
        .rfWrite    (rfWrite),
        .rfWriteAdd (rfWriteAdd),
        .rfIn       (rfIn),
        .rfWriteR7  (rfWriteR7),
        .rfInR7     (rfInR7),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [2:0]  add;
        logic [15:0] din;
        logic        wr7;
        logic [15:0] din7;
        logic        ret;
        logic [15:0] addr;
    } wb_rec_t;

    wb_rec_t     pend[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic wb_rec_t idle_rec();
        wb_rec_t r;
        r      = '0;
        r.wr   = 1'b1;
        r.wr7  = 1'b1;
        return r;
    endfunction

    // Expand an accepted instruction into its register writes.
    task automatic model_accept(output wb_rec_t e);
        wb_rec_t     r;
        int unsigned j;
        int          hi;
        e = idle_rec();
        if (inIsLM && inLMList != 8'h00) begin
            hi = 0;
            for (int i = 0; i < 8; i++) if (inLMList[i]) hi = i;
            j = 0;
            for (int i = 0; i < 8; i++) begin
                if (inLMList[i]) begin
                    r      = idle_rec();
                    r.addr = inLMBase + 16'(j * STRIDE);
                    if (i == 7) begin
                        r.wr7  = 1'b0;
                        r.din7 = r.addr + mem_key;
                    end else begin
                        r.wr  = 1'b0;
                        r.add = 3'(i);
                        r.din = r.addr + mem_key;
                    end
                    if (i == hi) begin
                        r.ret = 1'b1;
                        if (i != 7) begin
                            r.wr7  = 1'b0;
                            r.din7 = inPcNext;
                        end
                    end
                    pend.push_back(r);
                    j++;
                end
            end
        end else begin
            e.wr7  = 1'b0;
            e.din7 = inPcNext;
            e.ret  = 1'b1;
            if (!inIsLM && inRegWrite) begin
                if (inAdd == 3'd7) begin
                    e.din7 = inData;
                end else begin
                    e.wr  = 1'b0;
                    e.add = inAdd;
                    e.din = inData;
                end
            end
        end
    endtask

    task automatic tick();
        wb_rec_t e;
        wb_rec_t f;
        logic    acc;
        @(negedge clk);
        check_eq("inReady", inReady, (pend.size() == 0));
        if (pend.size() != 0) begin
            f = pend[0];
            check_eq("memAddr", memAddr, f.addr);
        end else begin
            check_eq("memAddr_idle", memAddr, 16'h0000);
        end
        acc = inValid && (pend.size() == 0);
        @(posedge clk);
        if (reset) begin
            pend.delete();
            e = idle_rec();
        end else if (pend.size() != 0) begin
            e = pend.pop_front();
        end else if (acc) begin
            model_accept(e);
        end else begin
            e = idle_rec();
        end
        #1;
        check_eq("rfWrite", rfWrite, e.wr);
        check_eq("rfWriteR7", rfWriteR7, e.wr7);
        check_eq("retired", retired, e.ret);
        if (!e.wr) begin
            check_eq("rfWriteAdd", rfWriteAdd, e.add);
            check_eq("rfIn", rfIn, e.din);
        end
        if (!e.wr7) begin
            check_eq("rfInR7", rfInR7, e.din7);
        end
    endtask

    task automatic drive_idle();
        inValid    = 1'b0;
        inRegWrite = 1'b0;
        inIsLM     = 1'b0;
    endtask

    task automatic drive_single(input logic rw, input logic [2:0] add,
                                input logic [15:0] data, input logic [15:0] pc);
        inValid    = 1'b1;
        inIsLM     = 1'b0;
        inRegWrite = rw;
        inAdd      = add;
        inData     = data;
        inPcNext   = pc;
    endtask

    task automatic drive_lm(input logic [7:0] list, input logic [15:0] base,
                            input logic [15:0] pc);
        inValid    = 1'b1;
        inIsLM     = 1'b1;
        inRegWrite = 1'b0;
        inLMList   = list;
        inLMBase   = base;
        inPcNext   = pc;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_rfIn"}, rfIn, 16'h0000);
        check_eq({tag, "_rfInR7"}, rfInR7, 16'h0000);
        check_eq({tag, "_rfWriteAdd"}, rfWriteAdd, 3'd0);
    endtask

    initial begin
        reset    = 1'b1;
        inAdd    = '0;
        inData   = '0;
        inPcNext = '0;
        inLMList = '0;
        inLMBase = '0;
        mem_key  = 16'hA000;
        drive_idle();
        tick();
        tick();
        reset = 1'b0;
        check_reset_values("rst");

        // Reset in the middle of an LM burst aborts it.
        drive_lm(8'h0F, 16'h0200, 16'h0050);
        tick();
        drive_idle();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_reset_values("rst_mid_lm");
        repeat (4) tick();

        // ALU result plus PC commit.
        drive_single(1'b1, 3'd3, 16'h1234, 16'h0011);
        tick();
        drive_idle();
        tick();

        // Result to R7 overrides PC.
        drive_single(1'b1, 3'd7, 16'h0400, 16'h0022);
        tick();
        drive_idle();
        tick();

        // No register write: PC only.
        drive_single(1'b0, 3'd2, 16'hDEAD, 16'h0023);
        tick();
        drive_idle();
        tick();

        // LM R0,R2,R5; upstream holds a follow-up instruction meanwhile.
        drive_lm(8'b0010_0101, 16'h0100, 16'h0033);
        tick();
        drive_single(1'b1, 3'd1, 16'hBEEF, 16'h0044);
        repeat (4) tick();
        drive_idle();
        tick();

        // LM of R7 only at the top of the address space.
        drive_lm(8'h80, 16'hFFFF, 16'h0055);
        tick();
        drive_idle();
        repeat (2) tick();

        // Empty LM list behaves as a PC-only retire.
        drive_lm(8'h00, 16'h1234, 16'h0066);
        tick();
        drive_idle();
        tick();

        // Full list across the 16-bit address wrap.
        drive_lm(8'hFF, 16'hFFFC, 16'h0077);
        tick();
        drive_idle();
        repeat (9) tick();

        mem_key = 16'($urandom);
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 99) < 2);
            inValid    = ($urandom_range(0, 9) < 7);
            inIsLM     = ($urandom_range(0, 3) == 0);
            inRegWrite = $urandom_range(0, 1) == 1;
            inAdd      = 3'($urandom);
            inData     = 16'($urandom);
            inPcNext   = 16'($urandom);
            inLMList   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            inLMBase   = 16'($urandom);
            tick();
        end
        reset = 1'b0;
        drive_idle();
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
